// File: rtl/ddr_package.sv
// Shared types, state encodings and constants for the DIMM read-data responder.
package ddr_package;

    typedef struct packed {
        logic [28:0] addr;
        logic        bl8;
    } rd_cmd_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_CL = 3'd1,
        PRE     = 3'd2,
        BURST   = 3'd3,
        POST    = 3'd4
    } rsp_state_t;

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_WAIT  = WAIT_CL;
    localparam logic [2:0] ST_PRE   = PRE;
    localparam logic [2:0] ST_BURST = BURST;
    localparam logic [2:0] ST_POST  = POST;

    localparam logic [63:0] UNINIT_PATTERN = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam int          BL8_BEATS      = 8;
    localparam int          BL4_BEATS      = 4;

    function automatic logic [7:0] beat_byte(input logic [63:0] word, input logic [2:0] k);
        return word[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ddr_cmd_fifo.sv
// Show-ahead synchronous FIFO used to queue read commands ahead of the burst engine.
module ddr_cmd_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dimm_read_responder.sv
// DIMM-side read-data driver: stores captured writes, replays queued reads as DQS-framed bursts.
// Optional build macro UNINIT_CHECK_EN flags reads of never-written entries.
module dimm_read_responder
    import ddr_package::*;
#(
    parameter int CL         = 11,
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock_t,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [28:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic        rd_cmd_valid,
    output logic        rd_cmd_ready,
    input  logic [28:0] rd_addr,
    input  logic        rd_bl8,
    output logic [7:0]  dq,
    output logic        dqs_t,
    output logic        dqs_c,
    output logic        dq_oe,
`ifdef UNINIT_CHECK_EN
    output logic        uninit_rd,
`endif
    output logic        busy
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int CMDW = $bits(rd_cmd_t);

    logic [63:0]     r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic [2:0]      r_state;
    logic [4:0]      r_cnt;
    logic [3:0]      r_beat;
    rd_cmd_t         r_cmd;
    logic [63:0]     r_word;
    logic [7:0]      r_dq;
    logic            r_dqs_t;
    logic            r_dqs_c;
    logic            r_dq_oe;
    logic            r_uninit;

    rd_cmd_t         w_push_cmd;
    rd_cmd_t         w_head_cmd;
    logic [CMDW-1:0] w_head_bits;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [IDXW-1:0] w_wr_idx;
    logic [IDXW-1:0] w_rd_idx;
    logic            w_bypass;
    logic            w_uninit;
    logic [63:0]     w_fetch;
    logic [3:0]      w_last;
    logic            w_unused;

    assign w_push_cmd   = '{addr: rd_addr, bl8: rd_bl8};
    assign w_head_cmd   = rd_cmd_t'(w_head_bits);
    assign w_push       = rd_cmd_valid && !w_full;
    assign w_pop        = (r_state == ST_IDLE) && !w_empty;
    assign rd_cmd_ready = !w_full;
    assign busy         = (r_state != ST_IDLE) || !w_empty;

    ddr_cmd_fifo #(
        .WIDTH (CMDW),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clock_t),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_cmd),
        .dout  (w_head_bits),
        .full  (w_full),
        .empty (w_empty)
    );

    // Upper address bits alias onto the same entry
    assign w_wr_idx = wr_addr[IDXW-1:0];
    assign w_rd_idx = r_cmd.addr[IDXW-1:0];
    assign w_bypass = wr_en && (w_wr_idx == w_rd_idx);
    assign w_uninit = !w_bypass && !r_valid[w_rd_idx];
    assign w_last   = r_cmd.bl8 ? 4'(BL8_BEATS) : 4'(BL4_BEATS);

    // Word presented to the beat register on PRE entry, write-first on a same-index write
    always_comb begin
        w_fetch = 64'h0;
        if (w_bypass) begin
            w_fetch = wr_data;
        end else if (r_valid[w_rd_idx]) begin
            w_fetch = r_mem[w_rd_idx];
        end else begin
`ifdef UNINIT_CHECK_EN
            w_fetch = UNINIT_PATTERN;
`else
            w_fetch = 64'h0;
`endif
        end
    end

    always_ff @(posedge clock_t) begin
        if (wr_en) begin
            r_mem[w_wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[w_wr_idx] <= 1'b1;
        end
    end

    // Burst engine; every output is set on the edge that enters the state it belongs to
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 5'd0;
            r_beat   <= 4'd0;
            r_cmd    <= '0;
            r_word   <= 64'h0;
            r_dq     <= 8'h00;
            r_dqs_t  <= 1'b0;
            r_dqs_c  <= 1'b1;
            r_dq_oe  <= 1'b0;
            r_uninit <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_cmd   <= w_head_cmd;
                        r_cnt   <= 5'(CL - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 5'd0) begin
                        r_state  <= ST_PRE;
                        r_word   <= w_fetch;
                        r_dq_oe  <= 1'b1;
                        r_dq     <= 8'h00;
                        r_dqs_t  <= 1'b0;
                        r_dqs_c  <= 1'b1;
                        r_uninit <= w_uninit;
`ifdef UNINIT_CHECK_EN
                        if (w_uninit) begin
                            $error("dimm_read_responder: read of unwritten entry, addr %h", r_cmd.addr);
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                ST_PRE: begin
                    r_state  <= ST_BURST;
                    r_dq     <= beat_byte(r_word, 3'd0);
                    r_dqs_t  <= 1'b1;
                    r_dqs_c  <= 1'b0;
                    r_beat   <= 4'd1;
                    r_uninit <= 1'b0;
                end
                ST_BURST: begin
                    if (r_beat == w_last) begin
                        r_state <= ST_POST;
                        r_dq    <= 8'h00;
                        r_dqs_t <= 1'b0;
                        r_dqs_c <= 1'b1;
                    end else begin
                        r_dq    <= beat_byte(r_word, r_beat[2:0]);
                        r_dqs_t <= ~r_beat[0];
                        r_dqs_c <= r_beat[0];
                        r_beat  <= r_beat + 4'd1;
                    end
                end
                ST_POST: begin
                    r_state <= ST_IDLE;
                    r_dq_oe <= 1'b0;
                    r_dq    <= 8'h00;
                    r_dqs_t <= 1'b0;
                    r_dqs_c <= 1'b1;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_dq_oe  <= 1'b0;
                    r_dq     <= 8'h00;
                    r_dqs_t  <= 1'b0;
                    r_dqs_c  <= 1'b1;
                    r_uninit <= 1'b0;
                end
            endcase
        end
    end

    assign dq    = r_dq;
    assign dqs_t = r_dqs_t;
    assign dqs_c = r_dqs_c;
    assign dq_oe = r_dq_oe;

`ifdef UNINIT_CHECK_EN
    assign uninit_rd = r_uninit;
    assign w_unused  = ^{wr_addr[28:IDXW], r_cmd.addr[28:IDXW]};
`else
    assign w_unused  = ^{wr_addr[28:IDXW], r_cmd.addr[28:IDXW], r_uninit};
`endif

endmodule

// File: tb/tb_dimm_read_responder.sv
// Directed bench for dimm_read_responder (CL=4); a negedge monitor frames each burst.
module tb_dimm_read_responder;

    logic        clock_t = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [28:0] wr_addr;
    logic [63:0] wr_data;
    logic        rd_cmd_valid;
    logic        rd_cmd_ready;
    logic [28:0] rd_addr;
    logic        rd_bl8;
    logic [7:0]  dq;
    logic        dqs_t;
    logic        dqs_c;
    logic        dq_oe;
    logic        busy;
    logic        uninit_rd;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

`ifdef UNINIT_CHECK_EN
    localparam logic [63:0] EXP_UNINIT = 64'hA5A5_A5A5_A5A5_A5A5;
`else
    localparam logic [63:0] EXP_UNINIT = 64'h0;
`endif

    logic [63:0] w3  [5] = '{64'hDEAD_BEEF_0123_4567, 64'h0F1E_2D3C_4B5A_6978,
                             64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001,
                             64'h1357_9BDF_2468_ACE0};
    logic        bl3 [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    int          b_rise [$];
    int          b_fall [$];
    int          b_len  [$];
    logic [63:0] b_word [$];

    dimm_read_responder #(.CL(4), .DEPTH(256), .FIFO_DEPTH(4)) dut (
        .clock_t      (clock_t),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_cmd_valid (rd_cmd_valid),
        .rd_cmd_ready (rd_cmd_ready),
        .rd_addr      (rd_addr),
        .rd_bl8       (rd_bl8),
        .dq           (dq),
        .dqs_t        (dqs_t),
        .dqs_c        (dqs_c),
        .dq_oe        (dq_oe),
`ifdef UNINIT_CHECK_EN
        .uninit_rd    (uninit_rd),
`endif
        .busy         (busy)
    );

`ifndef UNINIT_CHECK_EN
    assign uninit_rd = 1'b0;
`endif

    always #5 clock_t = ~clock_t;

    always @(posedge clock_t) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Burst framing: preamble, beats with alternating strobes, postamble
    initial begin
        logic [7:0] m_dq [16];
        logic [1:0] m_ts [16];
        int         m_n;
        int         m_rise;
        logic       m_active;
        logic [63:0] w;
        m_active = 1'b0;
        m_n      = 0;
        m_rise   = 0;
        forever begin
            @(negedge clock_t);
            if (reset) begin
                m_active = 1'b0;
                m_n      = 0;
            end else if (dq_oe) begin
                if (!m_active) begin
                    m_active = 1'b1;
                    m_rise   = cyc;
                    m_n      = 0;
                    chk("pre_dq", 64'(dq), 64'h0);
                    chk("pre_dqs", 64'({dqs_t, dqs_c}), 64'd1);
                end else if (m_n < 16) begin
                    m_dq[m_n] = dq;
                    m_ts[m_n] = {dqs_t, dqs_c};
                    m_n++;
                end
            end else if (m_active) begin
                m_active = 1'b0;
                w = 64'h0;
                for (int k = 0; k < m_n - 1; k++) begin
                    w[8*k +: 8] = m_dq[k];
                    chk("beat_dqs", 64'(m_ts[k]), (k % 2 == 0) ? 64'd2 : 64'd1);
                end
                if (m_n >= 1) begin
                    chk("post_dq", 64'(m_dq[m_n-1]), 64'h0);
                    chk("post_dqs", 64'(m_ts[m_n-1]), 64'd1);
                end
                b_rise.push_back(m_rise);
                b_fall.push_back(cyc);
                b_len.push_back(m_n - 1);
                b_word.push_back(w);
            end
        end
    end

    task automatic wr(input logic [28:0] addr, input logic [63:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clock_t);
        wr_en   = 1'b0;
    endtask

    task automatic issue(input logic [28:0] addr, input logic bl8, output int a);
        int t;
        t = 0;
        rd_cmd_valid = 1'b1;
        rd_addr      = addr;
        rd_bl8       = bl8;
        while (!rd_cmd_ready && t < 100) begin
            @(negedge clock_t);
            t++;
        end
        chk("issue_ready", 64'(rd_cmd_ready), 64'd1);
        @(posedge clock_t);
        #1 a = cyc;
        @(negedge clock_t);
        rd_cmd_valid = 1'b0;
    endtask

    task automatic wait_burst(output int rise, output int fall, output int len, output logic [63:0] word);
        int t;
        t = 0;
        while (b_word.size() == 0 && t < 200) begin
            @(negedge clock_t);
            t++;
        end
        chk("burst_timeout", 64'(b_word.size() != 0), 64'd1);
        if (b_word.size() != 0) begin
            rise = b_rise.pop_front();
            fall = b_fall.pop_front();
            len  = b_len.pop_front();
            word = b_word.pop_front();
        end else begin
            rise = 0;
            fall = 0;
            len  = 0;
            word = 64'h0;
        end
    endtask

    initial begin
        int          a;
        int          a1;
        int          as [5];
        int          rise;
        int          fall;
        int          len;
        int          prev_fall;
        logic [63:0] word;
        logic [63:0] exp;

        reset        = 1'b1;
        wr_en        = 1'b0;
        wr_addr      = 29'h0;
        wr_data      = 64'h0;
        rd_cmd_valid = 1'b0;
        rd_addr      = 29'h0;
        rd_bl8       = 1'b0;
        prev_fall    = 0;

        #12;
        chk("rst_dq", 64'(dq), 64'h0);
        chk("rst_dqs_t", 64'(dqs_t), 64'd0);
        chk("rst_dqs_c", 64'(dqs_c), 64'd1);
        chk("rst_oe", 64'(dq_oe), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(rd_cmd_ready), 64'd1);
        @(negedge clock_t);
        reset = 1'b0;
        repeat (2) @(negedge clock_t);

        // BL8 read: oe after A+CL+1, beats A+CL+2.., oe low after A+CL+BL+3
        wr(29'h10, 64'h1122_3344_5566_7788);
        issue(29'h10, 1'b1, a);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_burst(rise, fall, len, word);
        chk("t1_rise", 64'(rise), 64'(a + 5));
        chk("t1_fall", 64'(fall), 64'(a + 15));
        chk("t1_len", 64'(len), 64'd8);
        chk("t1_word", word, 64'h1122_3344_5566_7788);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // BL4 read uses the low half of the word
        issue(29'h10, 1'b0, a);
        wait_burst(rise, fall, len, word);
        chk("t2_rise", 64'(rise), 64'(a + 5));
        chk("t2_fall", 64'(fall), 64'(a + 11));
        chk("t2_len", 64'(len), 64'd4);
        chk("t2_word", word, 64'h0000_0000_5566_7788);

        // Five back-to-back commands fill the queue while the engine is busy
        for (int i = 0; i < 5; i++) wr(29'h20 + 29'(i), w3[i]);
        for (int i = 0; i < 5; i++) issue(29'h20 + 29'(i), bl3[i], as[i]);
        chk("t3_ready_full", 64'(rd_cmd_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            wait_burst(rise, fall, len, word);
            exp = bl3[i] ? w3[i] : {32'h0, w3[i][31:0]};
            chk("t3_word", word, exp);
            chk("t3_len", 64'(len), bl3[i] ? 64'd8 : 64'd4);
            if (i == 0) chk("t3_first_rise", 64'(rise), 64'(as[0] + 5));
            else        chk("t3_gap", 64'(rise - prev_fall), 64'd5);
            prev_fall = fall;
        end

        // Write landing on the PRE-entry edge is returned (write-first)
        wr(29'h30, 64'h5555_5555_5555_5555);
        issue(29'h30, 1'b1, a);
        repeat (4) @(negedge clock_t);
        wr(29'h30, 64'hAAAA_AAAA_AAAA_AAAA);
        wait_burst(rise, fall, len, word);
        chk("t4_rise", 64'(rise), 64'(a + 5));
        chk("t4_bypass", word, 64'hAAAA_AAAA_AAAA_AAAA);

        // Reset during beat 3 with two commands queued
        issue(29'h20, 1'b1, a1);
        issue(29'h21, 1'b1, a);
        issue(29'h22, 1'b1, a);
        while (cyc < a1 + 9) @(negedge clock_t);
        chk("t5_beat3", 64'(dq), 64'h01);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_oe", 64'(dq_oe), 64'd0);
        chk("t5_rst_dqs_c", 64'(dqs_c), 64'd1);
        chk("t5_rst_dqs_t", 64'(dqs_t), 64'd0);
        chk("t5_rst_dq", 64'(dq), 64'h0);
        repeat (2) @(negedge clock_t);
        reset = 1'b0;
        #1;
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_ready", 64'(rd_cmd_ready), 64'd1);
        repeat (40) @(negedge clock_t);
        chk("t5_no_burst", 64'(b_word.size()), 64'd0);
        chk("t5_oe_idle", 64'(dq_oe), 64'd0);

        // Valid bits cleared by reset, and a never-written entry
        issue(29'h10, 1'b1, a);
        wait_burst(rise, fall, len, word);
        chk("t6_after_rst", word, EXP_UNINIT);
        issue(29'h77, 1'b0, a);
        wait_burst(rise, fall, len, word);
        chk("t7_unwritten", word, {32'h0, EXP_UNINIT[31:0]});
        chk("t7_len", 64'(len), 64'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dimm_read_responder.md
Name: dimm_read_responder

Overview:
- DIMM-side read-data driver for the DDR4 testbench.
- Holds write data delivered by the write-capture path in a local array, accepts queued read commands, waits CL, then drives a DQS preamble, BL8 or BL4 beats of dq with toggling dqs_t/dqs_c, and a postamble.
- Mirrors the strobe/beat format the memory checker captures.
- Sits between the DIMM model and DDR_INTERFACE dq/dqs signals.

Parameters:
- CL, 11, read latency in clock_t cycles; legal range 2..31.
- DEPTH, 256, number of 64-bit storage entries; power of 2.
- FIFO_DEPTH, 4, read command queue depth; power of 2, ≥2.

Ports:
- clock_t  input  1  bit-rate clock, one dq beat per rising edge.
- reset  input  1  asynchronous active-high reset.
- wr_en  input  1  store wr_data at wr_addr this edge.
- wr_addr  input  29  physical_addr[31:3].
- wr_data  input  64  8 beats, beat k = wr_data[8k+7:8k].
- rd_cmd_valid  input  1  read command request.
- rd_cmd_ready  output  1  queue not full.
- rd_addr  input  29  read address, physical_addr[31:3].
- rd_bl8  input  1  1 = BL8, 0 = BL4.
- dq  output  8  read data beat.
- dqs_t  output  1  true strobe.
- dqs_c  output  1  complement strobe.
- dq_oe  output  1  driver enable.
- busy  output  1  engine not IDLE or queue non-empty.

Behaviour:
- Storage index:
  - Index = addr[$clog2(DEPTH)-1:0]; higher bits alias.
  - A per-entry valid bit is set by wr_en.
- Command accept:
  - A command is accepted on an edge with rd_cmd_valid && rd_cmd_ready; it is pushed into the FIFO.
  - rd_cmd_ready = !full.
  - Push while full is impossible by handshake.
- State machine: IDLE → WAIT_CL → PRE → BURST → POST → IDLE.
  - IDLE: when the FIFO is non-empty, pop at edge S, load counter = CL-1, go to WAIT_CL.
  - WAIT_CL: decrement each edge; at 0, go to PRE.
  - PRE (1 cycle): data word fetched (beat register loaded); dq_oe=1, dqs_t=0, dqs_c=1, dq=0.
  - BURST: BL beats (8 or 4 per rd_bl8). Beat k drives dq = word[8k+7:8k], dqs_t = ~k[0], dqs_c = k[0].
  - POST (1 cycle): dq_oe=1, dqs_t=0, dqs_c=1, dq=0; then IDLE.
- Latency: all outputs are registered. With an idle engine, accept at edge A → pop at A+1 → dq_oe high after edge A+CL+1 → first beat after A+CL+2 → dq_oe low after edge A+CL+BL+3.
- Back-to-back commands: the next command pops in IDLE on the edge after POST, giving a minimum gap of CL+1 cycles.
- Write/read same index: the fetch occurs on entry to PRE. A write on the same edge bypasses the array and is returned (write-first).
- Unwritten entry: returns 64'h0.
- Simultaneous push and pop on the same edge: both take effect; count unchanged.
- Reset behaviour:
  - Values: dq=0, dqs_t=0, dqs_c=1, dq_oe=0, busy=0, rd_cmd_ready=1, FIFO empty, state IDLE, all valid bits cleared. Array contents are not cleared.
  - Reset mid-burst: outputs go to reset values immediately (asynchronous); queued commands are dropped.
- BL4 with a 64-bit word uses word[31:0] only.

Optional Feature:
- Macro: UNINIT_CHECK_EN.
- Defined:
  - A read of an entry with valid=0 returns 64'hA5A5_A5A5_A5A5_A5A5.
  - Adds output uninit_rd (1 bit), pulsed high for one cycle in PRE.
  - Issues $error with the address.
- Undefined: returns 64'h0; no extra port; no message.

Decomposition:
- Shared package (ddr_package):
  - rd_cmd_t struct {addr[28:0], bl8}.
  - rsp_state_t enum {IDLE, WAIT_CL, PRE, BURST, POST}.
  - UNINIT_PATTERN constant.
  - BL8_BEATS=8, BL4_BEATS=4.
- Sub-module ddr_cmd_fifo:
  - Parameterised width/depth synchronous FIFO.
  - Ports: push, pop, full, empty, din, dout; async active-high reset.
  - Instantiated once for rd_cmd_t.

Test Plan:
- CL=4; write 0x1122334455667788 at addr 0x10; BL8 read accepted at edge 10 → dq_oe rises after edge 15; dq beats 0x88,0x77,…,0x11 after edges 16..23; dqs_t 1,0,1,0,…; dq_oe low after edge 25.
- BL4 read of the same addr → beats 0x88,0x77,0x66,0x55; postamble one cycle after the 4th beat.
- Push 5 commands back-to-back (FIFO_DEPTH=4, engine busy) → rd_cmd_ready low after the 4th queued; all reads return correct data in order with CL+1-cycle minimum gaps.
- Write 0xAAAA… and BL8 read of the same index with the write landing on the PRE-entry edge → returned data is 0xAAAA… (bypass).
- Assert reset during beat 3 of a burst with 2 commands queued → dq_oe=0, dqs_c=1 immediately; after release, no further bursts and busy=0.
- Read of a never-written addr → 64'h0; with UNINIT_CHECK_EN → 0xA5 beats and a uninit_rd pulse.
